// File: rtl/traffic_pkg.sv
// Shared lamp-bus indices and pedestrian controller state encoding.
// Consumed by the pedestrian signal controller and its bench.
package traffic_pkg;

    localparam int LIGHT_GREEN  = 0;
    localparam int LIGHT_YELLOW = 1;
    localparam int LIGHT_RED    = 2;

    typedef enum logic [1:0] {
        PED_IDLE,
        PED_WALK,
        PED_CLEAR,
        PED_FAULT
    } ped_state_t;

    // Exactly one lamp lit; anything else means the upstream controller is broken.
    function automatic logic lights_legal(input logic [2:0] l);
        return (l == 3'b001) || (l == 3'b010) || (l == 3'b100);
    endfunction

endpackage

// File: rtl/ped_signal_controller.sv
// Pedestrian WALK/CLEAR/DONT_WALK sequencer slaved to the traffic light bus.
// Walk is granted only on a red rising edge; a corrupt lights bus latches a safe fault state.
module ped_signal_controller
    import traffic_pkg::*;
#(
    parameter int WALK_TICKS  = 3,
    parameter int CLEAR_TICKS = 2,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       lights,
    input  logic             ped_button,
    output logic             walk_on,
    output logic             dont_walk_on,
    output logic             ped_pending,
    output logic [CNT_W-1:0] countdown,
    output logic             fault
);

    localparam int MAX_TICKS = (WALK_TICKS > CLEAR_TICKS) ? WALK_TICKS : CLEAR_TICKS;

    if (WALK_TICKS < 1) begin : g_bad_walk
        $error("WALK_TICKS must be >= 1");
    end
    if (CLEAR_TICKS < 1) begin : g_bad_clear
        $error("CLEAR_TICKS must be >= 1");
    end
    if ((2 ** CNT_W) <= MAX_TICKS) begin : g_bad_cnt_w
        $error("CNT_W too narrow for WALK_TICKS/CLEAR_TICKS");
    end

    ped_state_t state;
    logic       red_prev;
    logic       red_now;
    logic       red_rise;
    logic       illegal;
    logic       cnt_last;

    assign red_now  = lights[LIGHT_RED];
    assign red_rise = red_now & ~red_prev;
    assign illegal  = ~lights_legal(lights);
    assign cnt_last = (countdown == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= PED_IDLE;
            red_prev     <= 1'b1;
            walk_on      <= 1'b0;
            dont_walk_on <= 1'b1;
            ped_pending  <= 1'b0;
            countdown    <= '0;
            fault        <= 1'b0;
        end else begin
            red_prev <= red_now;
            if (illegal) begin
                state        <= PED_FAULT;
                fault        <= 1'b1;
                walk_on      <= 1'b0;
                dont_walk_on <= 1'b1;
                countdown    <= '0;
            end else begin
                case (state)
                    PED_IDLE: begin
                        if (red_rise && (ped_pending || ped_button)) begin
                            state        <= PED_WALK;
                            walk_on      <= 1'b1;
                            dont_walk_on <= 1'b0;
                            countdown    <= CNT_W'(WALK_TICKS);
                            ped_pending  <= 1'b0;
                        end else begin
                            walk_on      <= 1'b0;
                            dont_walk_on <= 1'b1;
                            countdown    <= '0;
                            if (ped_button) ped_pending <= 1'b1;
                        end
                    end
                    PED_WALK: begin
                        // Button presses are deliberately dropped while people are crossing.
                        if (!red_now) begin
                            state        <= PED_IDLE;
                            walk_on      <= 1'b0;
                            dont_walk_on <= 1'b1;
                            countdown    <= '0;
                        end else if (cnt_last) begin
                            state        <= PED_CLEAR;
                            walk_on      <= 1'b0;
                            dont_walk_on <= 1'b1;
                            countdown    <= CNT_W'(CLEAR_TICKS);
                        end else begin
                            countdown <= countdown - CNT_W'(1);
                        end
                    end
                    PED_CLEAR: begin
                        if (ped_button) ped_pending <= 1'b1;
                        if (!red_now || cnt_last) begin
                            state        <= PED_IDLE;
                            walk_on      <= 1'b0;
                            dont_walk_on <= 1'b1;
                            countdown    <= '0;
                        end else begin
                            dont_walk_on <= ~dont_walk_on;
                            countdown    <= countdown - CNT_W'(1);
                        end
                    end
                    PED_FAULT: begin
                        // Sticky until rst: legal lights never restore service.
                        walk_on      <= 1'b0;
                        dont_walk_on <= 1'b1;
                        countdown    <= '0;
                        fault        <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ped_signal_controller.sv
// Directed plus randomized bench for ped_signal_controller against a timeline model:
// service progress is tracked as elapsed cycles since the walk grant.
module tb_ped_signal_controller;
    import traffic_pkg::*;

    localparam int W  = 3;
    localparam int C  = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    lights;
    logic          ped_button;
    logic          walk_on;
    logic          dont_walk_on;
    logic          ped_pending;
    logic [CW-1:0] countdown;
    logic          fault;

    ped_signal_controller #(.WALK_TICKS(W), .CLEAR_TICKS(C), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .lights(lights), .ped_button(ped_button),
        .walk_on(walk_on), .dont_walk_on(dont_walk_on), .ped_pending(ped_pending),
        .countdown(countdown), .fault(fault)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: age = cycles since grant (0 = first walk cycle), -1 when not in service.
    int age;
    bit pend_m, fault_m, rp_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        age = -1; pend_m = 0; fault_m = 0; rp_m = 1;
    endtask

    task automatic model_step(input logic [2:0] l, input bit b);
        bit red, rise, legal;
        red   = l[LIGHT_RED];
        rise  = red && !rp_m;
        legal = $countones(l) == 1;
        rp_m  = red;
        if (fault_m) return;
        if (!legal) begin
            fault_m = 1; age = -1; return;
        end
        if (age < 0) begin
            if (rise && (pend_m || b)) begin
                age = 0; pend_m = 0;
            end else if (b) pend_m = 1;
        end else begin
            if (age >= W && b) pend_m = 1;
            if (!red) age = -1;
            else begin
                age++;
                if (age >= W + C) age = -1;
            end
        end
    endtask

    task automatic check_all(input string where);
        bit ew, ed; int ec;
        if (fault_m || age < 0) begin
            ew = 0; ed = 1; ec = 0;
        end else if (age < W) begin
            ew = 1; ed = 0; ec = W - age;
        end else begin
            ew = 0; ed = ((age - W) % 2) == 0; ec = C - (age - W);
        end
        chk({where, " walk_on"},      32'(walk_on),      32'(ew));
        chk({where, " dont_walk_on"}, 32'(dont_walk_on), 32'(ed));
        chk({where, " countdown"},    32'(countdown),    32'(ec));
        chk({where, " ped_pending"},  32'(ped_pending),  32'(pend_m));
        chk({where, " fault"},        32'(fault),        32'(fault_m));
    endtask

    task automatic tick(input logic [2:0] l, input bit b, input string where);
        lights = l; ped_button = b;
        model_step(l, b);
        @(posedge clk);
        #1;
        check_all(where);
    endtask

    task automatic async_reset(input string where);
        rst = 1'b1;
        #1;
        model_reset();
        check_all(where);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        logic [2:0] seq [3];
        seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100;

        // Reset while red is already lit; button held must only latch a request.
        rst = 1'b1; lights = 3'b100; ped_button = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick(3'b100, 1, "red at reset");

        // Pending request served on the next red rise: full WALK/CLEAR timeline.
        tick(3'b001, 0, "pre-rise green");
        tick(3'b100, 0, "red rise pending");
        chk("grant walk_on", 32'(walk_on), 32'd1);
        chk("grant countdown", 32'(countdown), 32'd3);
        for (int i = 0; i < 6; i++) tick(3'b100, 0, "walk/clear seq");
        chk("post clear countdown", 32'(countdown), 32'd0);

        // Button only at the rise cycle, then early red end aborts WALK.
        tick(3'b001, 0, "green idle");
        tick(3'b100, 1, "rise with button");
        chk("btn grant countdown", 32'(countdown), 32'd3);
        tick(3'b100, 0, "walk cnt2");
        tick(3'b001, 0, "abort");
        chk("abort walk_on", 32'(walk_on), 32'd0);
        tick(3'b010, 0, "after abort");
        tick(3'b100, 0, "rise no request");
        chk("no rearm walk_on", 32'(walk_on), 32'd0);

        // Button held through WALK is ignored; a CLEAR press is served next red.
        tick(3'b001, 0, "green");
        tick(3'b100, 1, "rise held btn");
        for (int i = 0; i < 3; i++) tick(3'b100, 1, "walk held btn");
        chk("walk ignores btn", 32'(ped_pending), 32'd0);
        tick(3'b100, 0, "clear");
        tick(3'b100, 1, "clear press");
        tick(3'b100, 0, "idle after clear");
        chk("clear press latched", 32'(ped_pending), 32'd1);
        tick(3'b001, 0, "green");
        tick(3'b100, 0, "rise serves clear press");
        chk("clear press granted", 32'(walk_on), 32'd1);

        // Asynchronous reset in the middle of WALK.
        tick(3'b100, 0, "walk before rst");
        async_reset("async rst in walk");

        // Randomized legal traffic cycles with random button presses.
        for (int r = 0; r < 40; r++) begin
            for (int p = 0; p < 3; p++) begin
                int dur;
                dur = $urandom_range(1, 8);
                for (int k = 0; k < dur; k++)
                    tick(seq[p], ($urandom_range(0, 3) == 0), "random");
            end
        end

        // Illegal code locks fault; legal traffic and buttons cannot clear it.
        tick(3'b001, 0, "pre-fault");
        tick(3'b011, 0, "illegal 011");
        chk("fault set", 32'(fault), 32'd1);
        for (int i = 0; i < 20; i++)
            tick(seq[i % 3], ($urandom_range(0, 1) == 1), "fault sticky");
        async_reset("async rst in fault");
        chk("fault cleared", 32'(fault), 32'd0);
        tick(3'b001, 0, "post rst green");
        tick(3'b000, 0, "illegal 000");
        tick(3'b111, 1, "illegal 111");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
